// File: rtl/sample_averager_pkg.sv
// Shared averaging definitions: FSM state encodings and the width/shift
// derivations from the samples-per-period count.
package sample_averager_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ACCUMULATE = 2'd1,
      DONE       = 2'd2
   } avg_state_e;

   // Right-shift amount that turns the accumulated sum into the mean.
   function automatic int avg_shift(input int count);
      return $clog2(count);
   endfunction

   // Accumulator width that cannot overflow within one full period.
   function automatic int avg_acc_width(input int count, input int width);
      return width + $clog2(count);
   endfunction

endpackage

// File: rtl/sample_averager_if.sv
// Averaging stimulus/result bundle between the stimulus generator (master)
// and one channel averager (slave).
interface sample_averager_if #(
   parameter int sample_width = 12
);
   logic                    clear;
   logic                    add;
   logic                    show;
   logic [sample_width-1:0] sample;
   logic [sample_width-1:0] average;
   logic                    average_valid;
   logic                    incomplete;
   logic                    overrun;

   modport master (
      output clear, add, show, sample,
      input  average, average_valid, incomplete, overrun
   );

   modport slave (
      input  clear, add, show, sample,
      output average, average_valid, incomplete, overrun
   );
endinterface

// File: rtl/sample_averager_rising_edge_detector.sv
// One-cycle pulse on each 0->1 transition of signal_i; a held level
// produces a single pulse.
module rising_edge_detector (
   input  logic clock,
   input  logic reset_n,
   input  logic signal_i,
   output logic edge_o
);
   logic prev_q;

   // History register tracks the input every cycle regardless of state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= signal_i;
      end
   end

   assign edge_o = signal_i & ~prev_q;
endmodule

// File: rtl/sample_averager.sv
// Channel averager: accumulates samples on add edges after a clear and
// latches the truncated mean (sum >> log2(sample_count)) on a show edge.
module sample_averager
   import sample_averager_pkg::*;
#(
   parameter int sample_count = 16,
   parameter int sample_width = 12
) (
   input  logic             clock,
   input  logic             reset_n,
   sample_averager_if.slave bus
);
   localparam int SHIFT = avg_shift(sample_count);
   localparam int ACC_W = avg_acc_width(sample_count, sample_width);
   localparam int CNT_W = SHIFT + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(sample_count);

   avg_state_e              state_q, state_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [sample_width-1:0] average_q, average_d;
   logic                    valid_q, valid_d;
   logic                    incomplete_q, incomplete_d;
   logic                    overrun_q, overrun_d;

   logic                    add_edge;
   logic                    show_edge;
   logic                    take;
   logic [ACC_W-1:0]        sum;
   logic [CNT_W-1:0]        cnt_next;

   rising_edge_detector u_add_edge (
      .clock    (clock),
      .reset_n  (reset_n),
      .signal_i (bus.add),
      .edge_o   (add_edge)
   );

   rising_edge_detector u_show_edge (
      .clock    (clock),
      .reset_n  (reset_n),
      .signal_i (bus.show),
      .edge_o   (show_edge)
   );

   // Sum and count including the current sample, so a show edge in the
   // same cycle as an add edge averages over the new sample too.
   assign take     = add_edge && (cnt_q < FULL);
   assign sum      = take ? acc_q + ACC_W'(bus.sample) : acc_q;
   assign cnt_next = take ? cnt_q + CNT_W'(1) : cnt_q;

   // Next-state and datapath update; clear overrides every other action.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      average_d    = average_q;
      valid_d      = valid_q;
      incomplete_d = incomplete_q;
      overrun_d    = overrun_q;

      if (bus.clear) begin
         state_d      = ACCUMULATE;
         acc_d        = '0;
         cnt_d        = '0;
         valid_d      = 1'b0;
         incomplete_d = 1'b0;
         overrun_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            ACCUMULATE: begin
               if (add_edge) begin
                  acc_d = sum;
                  cnt_d = cnt_next;
                  if (!take) begin
                     overrun_d = 1'b1;
                  end
               end
               if (show_edge) begin
                  average_d    = sum[ACC_W-1:SHIFT];
                  valid_d      = 1'b1;
                  incomplete_d = (cnt_next < FULL);
                  state_d      = DONE;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and result registers, all cleared by asynchronous reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         average_q    <= '0;
         valid_q      <= 1'b0;
         incomplete_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         average_q    <= average_d;
         valid_q      <= valid_d;
         incomplete_q <= incomplete_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.average       = average_q;
   assign bus.average_valid = valid_q;
   assign bus.incomplete    = incomplete_q;
   assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_sample_averager.sv
// Directed bench for sample_averager with sample_count=4, sample_width=8.
module tb_sample_averager;
   logic clock;
   logic reset_n;

   sample_averager_if #(.sample_width(8)) bus ();

   sample_averager #(
      .sample_count (4),
      .sample_width (8)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       clr;
      logic       add;
      logic       show;
      logic [7:0] smp;
      logic [7:0] avg;
      logic       vld;
      logic       inc;
      logic       ovr;
   } vec_t;

   vec_t tbl[$];
   int   total  = 0;
   int   passed = 0;

   task automatic push(input logic clr, input logic add, input logic show,
                       input logic [7:0] smp, input logic [7:0] avg,
                       input logic vld, input logic inc, input logic ovr);
      vec_t v;
      v.clr = clr; v.add = add; v.show = show; v.smp = smp;
      v.avg = avg; v.vld = vld; v.inc = inc; v.ovr = ovr;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_out(input string tag, input int avg, input int vld,
                          input int inc, input int ovr);
      chk({tag, ".average"}, int'(bus.average), avg);
      chk({tag, ".valid"}, int'(bus.average_valid), vld);
      chk({tag, ".incomplete"}, int'(bus.incomplete), inc);
      chk({tag, ".overrun"}, int'(bus.overrun), ovr);
   endtask

   // Drive one cycle of inputs just after an edge, then sample after the next.
   task automatic step(input logic clr, input logic add, input logic show,
                       input logic [7:0] smp);
      bus.clear  = clr;
      bus.add    = add;
      bus.show   = show;
      bus.sample = smp;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n    = 1'b0;
      bus.clear  = 1'b0;
      bus.add    = 1'b0;
      bus.show   = 1'b0;
      bus.sample = 8'd0;

      // Normal period: 10,20,30,40 -> 25
      push(1,0,0,  0,  0,0,0,0);
      push(0,1,0, 10,  0,0,0,0);
      push(0,0,0,  0,  0,0,0,0);
      push(0,1,0, 20,  0,0,0,0);
      push(0,0,0,  0,  0,0,0,0);
      push(0,1,0, 30,  0,0,0,0);
      push(0,0,0,  0,  0,0,0,0);
      push(0,1,0, 40,  0,0,0,0);
      push(0,0,1,  0, 25,1,0,0);
      push(0,1,1, 99, 25,1,0,0);   // DONE ignores edges
      push(1,0,0,  0, 25,0,0,0);   // clear keeps average
      // Short period: three samples of 100 -> 75, incomplete
      push(0,1,0,100, 25,0,0,0);
      push(0,0,0,  0, 25,0,0,0);
      push(0,1,0,100, 25,0,0,0);
      push(0,0,0,  0, 25,0,0,0);
      push(0,1,0,100, 25,0,0,0);
      push(0,0,0,  0, 25,0,0,0);
      push(0,0,1,  0, 75,1,1,0);
      push(1,0,0,  0, 75,0,0,0);
      // Overrun: five samples of 255 -> 255, overrun after fifth edge
      push(0,1,0,255, 75,0,0,0);
      push(0,0,0,  0, 75,0,0,0);
      push(0,1,0,255, 75,0,0,0);
      push(0,0,0,  0, 75,0,0,0);
      push(0,1,0,255, 75,0,0,0);
      push(0,0,0,  0, 75,0,0,0);
      push(0,1,0,255, 75,0,0,0);
      push(0,0,0,  0, 75,0,0,0);
      push(0,1,0,255, 75,0,0,1);
      push(0,0,1,  0,255,1,0,1);

      #3;
      chk_out("reset", 0, 0, 0, 0);
      #9 reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk_out("post_reset_idle", 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].clr, tbl[i].add, tbl[i].show, tbl[i].smp);
         chk_out($sformatf("vec%0d", i), int'(tbl[i].avg), int'(tbl[i].vld),
                 int'(tbl[i].inc), int'(tbl[i].ovr));
      end

      // Level handling: add held 3 cycles counts once, then 3 more edges.
      step(1, 0, 0, 0);
      step(0, 1, 0, 50);
      step(0, 1, 0, 50);
      step(0, 1, 0, 50);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0);
         step(0, 1, 0, 50);
      end
      step(0, 0, 0, 0);
      chk_out("level_pre_show", 255, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 0);
         chk($sformatf("level_show%0d.average", i), int'(bus.average), 50);
         chk($sformatf("level_show%0d.valid", i), int'(bus.average_valid), 1);
      end
      chk("level.incomplete", int'(bus.incomplete), 0);

      // Reset mid-period clears outputs asynchronously.
      step(1, 0, 0, 0);
      step(0, 1, 0, 10);
      step(0, 0, 0, 0);
      step(0, 1, 0, 10);
      chk_out("pre_reset", 50, 0, 0, 0);
      reset_n = 1'b0;
      #1;
      chk_out("async_reset", 0, 0, 0, 0);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1;
      step(0, 0, 0, 0);
      step(0, 1, 0, 10);
      step(0, 0, 0, 0);
      step(0, 1, 1, 20);
      chk_out("no_clear_after_reset", 0, 0, 0, 0);
      step(0, 0, 0, 0);

      // Priority: clear wins over add edge; add+show on 4th sample.
      step(1, 1, 0, 99);
      chk_out("clear_with_add", 0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 10);
         step(0, 0, 0, 0);
      end
      chk("prio_pre.valid", int'(bus.average_valid), 0);
      step(0, 1, 1, 50);
      chk_out("add_show_same", 20, 1, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/sample_averager.md
Name: sample_averager

Overview:
- Consumer end of the averaging stimulus interface. Accumulates `sample` on each `add` pulse after `clear`. On `show`, presents the mean of the accumulated samples.
- One instance per measured channel. All instances share one stimulus generator's `clear`/`add`/`show` lines.
- Mean is computed by right shift, so `sample_count` is restricted to powers of two.

Parameters:
- sample_count, 16, samples per averaging period; power of two, ≥2.
- sample_width, 12, bit width of `sample` and `average` (unsigned).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  start a new averaging period (level; acted on every cycle high).
- add  input  1  sample strobe; a rising edge captures one sample.
- show  input  1  result request; a rising edge latches the mean.
- sample  input  sample_width  unsigned sample, valid in the cycle `add` rises.
- average  output  sample_width  registered mean.
- average_valid  output  1  high from the result latch until the next clear/reset.
- incomplete  output  1  mean was latched with fewer than `sample_count` samples.
- overrun  output  1  more than `sample_count` add edges seen this period.

Behaviour:
- Reset (`reset_n` low, asynchronous):
  - State is IDLE.
  - Accumulator, sample counter, edge-detect history, `average`, `average_valid`, `incomplete` and `overrun` are all 0.
- Edge detection:
  - `add_edge` = `add` & ~`add_prev`; `show_edge` = `show` & ~`show_prev`.
  - The history registers always track their inputs, in every state.
  - A level held high counts once.
- Accumulator:
  - Width is sample_width + log2(sample_count), so it never overflows within sample_count samples.
  - Counter width is log2(sample_count)+1.
- IDLE:
  - `add`/`show` edges are ignored.
  - `clear` high moves to ACCUMULATE.
- Clear, any state:
  - `clear` high has priority over everything else in the same cycle.
  - Next cycle: accumulator=0, count=0, `overrun`=0, `incomplete`=0, `average_valid`=0, state ACCUMULATE.
  - `average` holds its previous value.
- ACCUMULATE:
  - `add_edge` with count<sample_count: accumulator += `sample`, count += 1.
  - `add_edge` with count==sample_count: sample discarded, `overrun`=1 (sticky until clear/reset).
  - `show_edge`: next cycle `average` = (accumulator [+ `sample` if `add_edge` same cycle and count<sample_count]) >> log2(sample_count), truncating. Also next cycle: `average_valid`=1, `incomplete` = (final count < sample_count). State goes to DONE.
- Simultaneous `add_edge` and `show_edge`: the sample is included before the mean is computed.
- DONE:
  - `add`/`show` edges are ignored; outputs hold.
  - `clear` returns to ACCUMULATE.
- Latency: `average_valid` rises exactly 1 clock after the cycle in which `show_edge` is detected.
- Reset mid-period: all state is lost. No sample is captured until the next `clear`.
- Stimulus compatibility: `add` toggles every cycle and `show` stays high until the next reset. Edge detection therefore yields exactly `sample_count` captures and one result per period.

Decomposition:
- Shared averaging package/include holds:
  - state encodings IDLE=2'd0, ACCUMULATE=2'd1, DONE=2'd2;
  - accumulator-width and shift-amount derivation from sample_count, reused by the stimulus generator.
- One natural sub-module: `rising_edge_detector` (clock, reset_n, signal, edge). Instantiated twice, for `add` and `show`.
- Accumulator, counter and FSM stay in the top module.

Test Plan:
- Normal period (sample_count=4, sample_width=8): reset_n, clear, add edges with samples 10,20,30,40, then show edge → `average`=25 one cycle after the show edge; `average_valid`=1, `incomplete`=0, `overrun`=0.
- Short period: clear, three add edges of 100, show edge → `average`=75 (300>>2), `incomplete`=1, `average_valid`=1.
- Overrun: clear, five add edges of 255, show → `overrun`=1 after the fifth edge, `average`=255 (1020>>2), `incomplete`=0.
- Level handling: `add` held high 3 cycles with sample=50, then toggled 3 more edges with 50 → count 4, `average`=50. `show` held high 10 cycles → `average_valid` asserted once and stays, `average` unchanged.
- Reset mid-period: after 2 adds, pulse reset_n low → all outputs 0 immediately (asynchronous). Subsequent add/show without clear → outputs remain 0.
- Priority: clear and an add edge (sample=99) in the same cycle → count=0, accumulator=0. Add edge and show edge in the same cycle as the 4th sample (10,10,10,50) → `average`=20.
